activation_repacker: RTL and testbench

//  Downstream of the 48-output layer cluster. Accepts its 4-bit activation stream: 48 values per frame, image-major
//  (sample n: image = n/16, neuron = n%16). Re-emits each frame as 16 packed 12-bit words, {img2,img1,img0} per neuron,

---
 rtl/activation_repacker_pkg.sv | 20 ++
 rtl/activation_repacker_bank.sv | 27 ++
 rtl/activation_repacker.sv | 88 ++++++++
 tb/tb_activation_repacker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/activation_repacker_pkg.sv
// Shared layer-cluster constants and derived widths for the activation repacker.
package activation_repacker_pkg;

  localparam int ABITS       = 4;
  localparam int NUM_NEURONS = 16;
  localparam int NUM_IMAGES  = 3;
  localparam int LAYER_OUT   = NUM_IMAGES * NUM_NEURONS;
  localparam int X_WIDTH     = NUM_IMAGES * ABITS;

  localparam int CNT_W = 6;
  localparam int IDX_W = 4;
  localparam int IMG_W = 2;

  typedef logic [ABITS-1:0]   act_t;
  typedef logic [X_WIDTH-1:0] word_t;

  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(LAYER_OUT - 1);
  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(NUM_NEURONS - 1);

endpackage

// File: rtl/activation_repacker_bank.sv
// One 3x16x4 activation bank: single write port, 12-bit packed read of all images for one neuron.
module act_bank
  import activation_repacker_pkg::*;
(
  input  logic             CLK,
  input  logic             we,
  input  logic [IMG_W-1:0] img,
  input  logic [IDX_W-1:0] idx,
  input  act_t             d,
  input  logic [IDX_W-1:0] rd_idx,
  output word_t            q
);

  act_t mem [NUM_IMAGES][NUM_NEURONS];

  always_ff @(posedge CLK) begin
    if (we && (img < IMG_W'(NUM_IMAGES))) begin
      mem[img][idx] <= d;
    end
  end

  // Image 0 lands in the low nibble of the packed word.
  for (genvar i = 0; i < NUM_IMAGES; i++) begin : g_pack
    assign q[i*ABITS +: ABITS] = mem[i][rd_idx];
  end

endmodule

// File: rtl/activation_repacker.sv
// Ping-pong repacker: 48 image-major activations in, 16 neuron-major {img2,img1,img0} words out.
module activation_repacker
  import activation_repacker_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  act_t        s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output word_t       m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [1:0]  status
);

  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       full;
  logic [1:0]       full_next;
  logic             wr_bank_next;
  logic             accept;
  logic             wr_last;
  logic             rd_fire;
  logic             rd_last;
  word_t            q0;
  word_t            q1;

  assign accept  = s_tvalid & s_tready;
  assign wr_last = accept & (wr_cnt == WR_LAST);
  assign rd_fire = m_tvalid & m_tready;
  assign rd_last = rd_fire & (rd_idx == RD_LAST);

  // Set and clear always hit different banks, so both can apply in one cycle.
  always_comb begin
    full_next = full;
    if (wr_last) full_next[wr_bank] = 1'b1;
    if (rd_last) full_next[rd_bank] = 1'b0;
    wr_bank_next = wr_bank ^ wr_last;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_cnt   <= '0;
      rd_idx   <= '0;
      full     <= 2'b00;
      s_tready <= 1'b0;
    end else begin
      full     <= full_next;
      wr_bank  <= wr_bank_next;
      s_tready <= ~full_next[wr_bank_next];
      if (accept) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (rd_fire) rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
      if (rd_last) rd_bank <= ~rd_bank;
    end
  end

  act_bank u_bank0 (
    .CLK    (CLK),
    .we     (accept & ~wr_bank),
    .img    (wr_cnt[5:4]),
    .idx    (wr_cnt[3:0]),
    .d      (s_tdata),
    .rd_idx (rd_idx),
    .q      (q0)
  );

  act_bank u_bank1 (
    .CLK    (CLK),
    .we     (accept & wr_bank),
    .img    (wr_cnt[5:4]),
    .idx    (wr_cnt[3:0]),
    .d      (s_tdata),
    .rd_idx (rd_idx),
    .q      (q1)
  );

  // Bank contents are never reset, so gate the data until a frame is ready.
  assign m_tvalid = full[rd_bank];
  assign m_tdata  = m_tvalid ? (rd_bank ? q1 : q0) : '0;
  assign m_tlast  = m_tvalid & (rd_idx == RD_LAST);
  assign status   = full;

endmodule

// File: tb/tb_activation_repacker.sv
// Scoreboard bench for activation_repacker: accepted inputs feed a frame model, a monitor checks every output word.
module tb_activation_repacker;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [11:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [1:0]  status;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]  inBuf[$];
  logic [12:0] expQ[$];

  activation_repacker dut (
    .CLK      (CLK),
    .RST      (RST),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .status   (status)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: a complete 48-sample frame becomes 16 words {img2[k],img1[k],img0[k]}.
  always @(negedge CLK) begin
    if (!RST) begin
      inBuf.delete();
      expQ.delete();
    end else begin
      if (m_tvalid) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word at %0t", m_tdata, $time);
        end else begin
          checkOutput("m_tdata", 32'(m_tdata), 32'(expQ[0][11:0]));
          checkOutput("m_tlast", 32'(m_tlast), 32'(expQ[0][12]));
          if (m_tready) void'(expQ.pop_front());
        end
      end
      if (s_tvalid && s_tready) begin
        inBuf.push_back(s_tdata);
        if (inBuf.size() == 48) begin
          for (int k = 0; k < 16; k++) begin
            expQ.push_back({(k == 15), inBuf[32+k], inBuf[16+k], inBuf[k]});
          end
          inBuf.delete();
        end
      end
    end
  end

  function automatic logic [3:0] pattern(input int mode, input int n);
    case (mode)
      0:       return 4'(n % 16);
      1:       return 4'((n % 48) / 16 + 1);
      default: return 4'($urandom);
    endcase
  endfunction

  // rpct < 0 leaves m_tready untouched; checkReady asserts s_tready every cycle.
  task automatic applyStimulus(input int count, input int mode, input int vpct, input int rpct,
                               input bit checkReady);
    int n = 0;
    int budget = count * 8 + 200;
    logic [3:0] cur;
    cur = pattern(mode, 0);
    while (n < count && budget > 0) begin
      @(posedge CLK); #1;
      budget--;
      if (rpct >= 0) m_tready = ($urandom_range(99) < rpct);
      s_tvalid = ($urandom_range(99) < vpct);
      s_tdata  = cur;
      if (checkReady) checkOutput("s_tready_held", 32'(s_tready), 32'd1);
      if (s_tvalid && s_tready) begin
        n++;
        cur = pattern(mode, n);
      end
    end
    if (n < count) reportTimeout("input_timeout");
    @(posedge CLK); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drainOutputs(input int rpct);
    int budget = 600;
    while ((expQ.size() != 0 || m_tvalid) && budget > 0) begin
      m_tready = ($urandom_range(99) < rpct);
      @(posedge CLK); #1;
      budget--;
    end
    if (budget == 0) reportTimeout("drain_timeout");
    checkOutput("status_idle", 32'(status), 32'd0);
  endtask

  task automatic resetDut();
    @(posedge CLK); #1;
    RST = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    @(posedge CLK); #1;
    checkOutput("rst_s_tready", 32'(s_tready), 32'd0);
    checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_m_tlast",  32'(m_tlast),  32'd0);
    checkOutput("rst_m_tdata",  32'(m_tdata),  32'd0);
    checkOutput("rst_status",   32'(status),   32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    checkOutput("rst_release_ready", 32'(s_tready), 32'd1);
  endtask

  initial begin
    bit found;
    resetDut();

    $display("[TB] single frame, counting pattern");
    m_tready = 1'b1;
    applyStimulus(48, 0, 100, 100, 1'b0);
    drainOutputs(100);

    $display("[TB] ordering, image-id pattern");
    applyStimulus(48, 1, 100, 100, 1'b0);
    drainOutputs(100);

    $display("[TB] back-pressure with both banks full");
    applyStimulus(96, 2, 100, 0, 1'b0);
    checkOutput("bp_s_tready", 32'(s_tready), 32'd0);
    checkOutput("bp_status", 32'(status), 32'd3);
    m_tready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge CLK); #1;
      if (m_tvalid && m_tlast) begin
        checkOutput("bp_still_blocked", 32'(s_tready), 32'd0);
        @(posedge CLK); #1;
        checkOutput("bp_reopen", 32'(s_tready), 32'd1);
        found = 1'b1;
      end
    end
    if (!found) reportTimeout("bp_last_word");
    drainOutputs(100);

    $display("[TB] back-to-back frames");
    applyStimulus(4 * 48, 2, 100, 100, 1'b1);
    drainOutputs(100);

    $display("[TB] random valid/ready over 20 frames");
    applyStimulus(20 * 48, 2, 50, 50, 1'b0);
    drainOutputs(50);

    $display("[TB] reset during fill");
    applyStimulus(30, 2, 100, 100, 1'b0);
    resetDut();
    m_tready = 1'b1;
    applyStimulus(48, 0, 100, 100, 1'b0);
    drainOutputs(100);

    $display("[TB] reset during drain");
    applyStimulus(48, 2, 100, 0, 1'b0);
    m_tready = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    resetDut();
    m_tready = 1'b1;
    applyStimulus(48, 1, 100, 100, 1'b0);
    drainOutputs(100);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("partial_empty", 32'(inBuf.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
